// File: rtl/ghr_spec_ctrl.sv
// ghr_spec_ctrl: speculative/architectural global-history controller with in-order branch FIFO
// Ports: clk, rst (async active-high); pred_valid/pred_taken/pred_ready push a prediction,
// resolve_valid/resolve_taken pop the oldest branch, mispredict flags a wrong head guess,
// flush clears all in-flight state; spec_history, arch_history, inflight_count are state outputs.
// Optional GHR_SPEC_CHECKPOINT_EN: per-entry history checkpoints used for mispredict recovery.
module ghr_spec_ctrl #(
   parameter int HISTORY_SIZE = 8,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           pred_valid,
   input  logic                           pred_taken,
   output logic                           pred_ready,
   input  logic                           resolve_valid,
   input  logic                           resolve_taken,
   output logic                           mispredict,
   input  logic                           flush,
   output logic [HISTORY_SIZE-1:0]        spec_history,
   output logic [HISTORY_SIZE-1:0]        arch_history,
   output logic [$clog2(DEPTH+1)-1:0]     inflight_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   logic [DEPTH-1:0] dir;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic res, push;
   logic [HISTORY_SIZE-1:0] arch_nxt, recov;
   assign pred_ready = inflight_count != FULL;
   assign res = resolve_valid && inflight_count != '0;
   assign mispredict = res && (resolve_taken != dir[rd_ptr]);
   // wrong-path pushes die with the mispredict/flush that squashes the FIFO
   assign push = pred_valid && pred_ready && !mispredict && !flush;
   assign arch_nxt = res ? {arch_history[HISTORY_SIZE-2:0], resolve_taken} : arch_history;
`ifdef GHR_SPEC_CHECKPOINT_EN
   logic [HISTORY_SIZE-1:0] ckpt [DEPTH];
   always_ff @(posedge clk)
      if (push) ckpt[wr_ptr] <= spec_history;
   assign recov = {ckpt[rd_ptr][HISTORY_SIZE-2:0], resolve_taken};
   // the head checkpoint must always match committed history when that branch resolves
   always @(posedge clk)
      if (!rst && res) assert (ckpt[rd_ptr] == arch_history);
`else
   assign recov = arch_nxt;
`endif
   always_ff @(posedge clk)
      if (push) dir[wr_ptr] <= pred_taken;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spec_history <= '0;
         arch_history <= '0;
         inflight_count <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         arch_history <= arch_nxt;
         if (flush || mispredict) begin
            spec_history <= flush ? arch_nxt : recov;
            inflight_count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) begin
               spec_history <= {spec_history[HISTORY_SIZE-2:0], pred_taken};
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (res) rd_ptr <= rd_ptr + PW'(1);
            inflight_count <= inflight_count + CW'(push) - CW'(res);
         end
      end
   end
endmodule
